ctrl_mem_datos: RTL and testbench
=================================

# ctrl_mem_datos

Data-memory access controller between the RV32I core's load/store path and the 512×32 word-addressed `ram`. It accepts one byte-addressed load or store per handshake and maps it onto `ram`'s single-word read and write ports. Byte and halfword stores are done as read-modify-write, because `ram` has no byte enables. Loads return data sign- or zero-extended to 32 bits. Misaligned, out-of-range and illegal-size accesses are reported as errors and never touch `ram`.

## Interface
- `DIR_BASE`, default 32'h0000_0000: byte base address of the RAM window. Must be aligned to the window size.
- `ANCHO_DIR`, default 9: width of the `ram` word address. The window size is 4·2^ANCHO_DIR bytes (2 KiB).

Ports (clock and reset first):
- `clk`  in  1  system clock. All registers update on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cpu_valido`  in  1  request valid.
- `cpu_listo`  out  1  controller ready to accept a request.
- `cpu_esc`  in  1  1 = store, 0 = load.
- `cpu_dir`  in  32  byte address.
- `cpu_tam`  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- `cpu_sin_signo`  in  1  zero-extend loads (LBU/LHU).
- `cpu_dat_w`  in  32  store data, right-aligned.
- `cpu_fin`  out  1  one-cycle completion pulse.
- `cpu_error`  out  1  valid with `cpu_fin`: the access was rejected.
- `cpu_dat_r`  out  32  load result, valid with `cpu_fin` on loads.
- `dir_w`  out  ANCHO_DIR  to `ram`: write word address.
- `hab_w`  out  1  to `ram`: write enable.
- `dat_w`  out  32  to `ram`: write data.
- `dir_r`  out  ANCHO_DIR  to `ram`: read word address.
- `hab_r`  out  1  to `ram`: read enable.
- `dat_r`  in  32  from `ram`: read data, valid the cycle after `hab_r` is sampled.

## Operation

**State machine.** States: REPOSO, ACCESO, DATO, RESP.
- `cpu_listo` = (state == REPOSO).
- `cpu_fin` = (state == RESP).

**Handshake.** A request is accepted at a rising edge where `cpu_valido` and `cpu_listo` are both 1. At acceptance the controller latches `cpu_esc`, `cpu_dir`, `cpu_tam`, `cpu_sin_signo` and `cpu_dat_w`. The core may change its inputs afterwards.

**Error check** (at acceptance). The request is an error if any of these holds:
- `cpu_tam` = 11;
- half access with dir[0] = 1;
- word access with dir[1:0] ≠ 00;
- dir[31:ANCHO_DIR+2] ≠ DIR_BASE[31:ANCHO_DIR+2].

On error: REPOSO→RESP, `cpu_error` = 1, `cpu_dat_r` unchanged, no `ram` access.

**Word index.** dir[ANCHO_DIR+1:2].

**Transitions for a valid request.** REPOSO→ACCESO.
- ACCESO, word store: `hab_w` = 1, `dat_w` = latched data. Next state RESP.
- ACCESO, load or sub-word store: `hab_r` = 1. Next state DATO.
- DATO, load: the selected lane of `dat_r` is extended into `cpu_dat_r`, which is registered on entry to RESP.
  - Byte lane = dir[1:0]; half lane = dir[1].
  - Sign-extend unless `cpu_sin_signo` = 1.
- DATO, sub-word store: `hab_w` = 1. `dat_w` = `dat_r` with the addressed byte or half lane replaced by data[7:0] or data[15:0]. Other lanes are preserved bit-exact.
- RESP always goes to REPOSO.

**RAM-side outputs.**
- `hab_r` and `hab_w` are decoded combinationally from state and are never both 1.
- `dir_r`, `dir_w` and `dat_w` come from latched registers.
- A store never updates `cpu_dat_r`.

## Timing
- E0 = acceptance edge.
- Latency from E0 to `cpu_fin` high:
  - error: first cycle after E0;
  - word store: after E1 (2 cycles);
  - load or sub-word store: after E2 (3 cycles).
- The `ram` write takes effect at E1 (word store) or E2 (sub-word store).
- `cpu_fin` and `cpu_error` are high for exactly one cycle.
- Next acceptance is no earlier than the edge ending RESP.
- Reset values:
  - state REPOSO, so `cpu_listo` = 1;
  - `cpu_fin`, `cpu_error`, `hab_w`, `hab_r` = 0;
  - `cpu_dat_r`, `dat_w`, `dir_w`, `dir_r` = 0.
- Reset asserted mid-operation: `hab_w` and `hab_r` drop immediately, no partial write is issued, and the in-flight request is discarded with no `cpu_fin`.

## Structure
- Shared include `mem_defs.vh` holds:
  - size codes TAM_BYTE, TAM_MEDIA, TAM_PALABRA;
  - state encodings;
  - RAM depth constants, shared with `ram`.
- Sub-module `extrae_carga` (combinational): lane select plus sign/zero extension. Inputs: 32-bit word, dir[1:0], tam, sin_signo.
- The store lane merge stays inline.

## Test plan
- Store word 0xAAAA_AAAA at 0x7FC, then load word from 0x7FC:
  - store: `hab_w` one cycle with `dir_w` = 511, `cpu_fin` after E1;
  - load: `hab_r` one cycle, `cpu_dat_r` = 0xAAAA_AAAA with `cpu_fin` after E2.
- Store word 0x8765_43F0 at 0x10, then load and check:
  - LB 0x10 → 0xFFFF_FFF0;
  - LBU 0x10 → 0x0000_00F0;
  - LH 0x12 → 0xFFFF_8765;
  - LHU 0x12 → 0x0000_8765.
- SB 0x11 with data 0x0000_00CC into the word above:
  - `hab_r` then `hab_w` on consecutive cycles, `dat_w` = 0x8765_CCF0;
  - a following LW 0x10 returns 0x8765_CCF0.
- Error cases, each with `cpu_error` = 1 and `cpu_fin` one cycle after acceptance, and `hab_r`/`hab_w` never asserted:
  - LH 0x11;
  - LW 0x12;
  - `cpu_tam` = 11;
  - LW 0x800.
- Drive `rst_n` low during DATO of SB 0x10 with data 0x55:
  - no `hab_w`, all outputs at reset values;
  - LW 0x10 after reset still returns 0x8765_CCF0.
- Hold `cpu_valido` high across three back-to-back requests:
  - `cpu_listo` low in ACCESO, DATO and RESP;
  - each request is accepted once, in order, with exactly one `cpu_fin` per request.

Source files
------------

// File: rtl/ctrl_mem_datos_pkg.sv
// ctrl_mem_datos_pkg: shared definitions for the data-memory controller
// size codes, FSM states and ram geometry
package ctrl_mem_datos_pkg;

  localparam logic [1:0] TAM_BYTE    = 2'b00;
  localparam logic [1:0] TAM_MEDIA   = 2'b01;
  localparam logic [1:0] TAM_PALABRA = 2'b10;
  localparam logic [1:0] TAM_ILEGAL  = 2'b11;

  localparam int RAM_ANCHO_DIR = 9;
  localparam int RAM_PROF      = 1 << RAM_ANCHO_DIR;

  typedef enum logic [1:0] {
    REPOSO = 2'b00,
    ACCESO = 2'b01,
    DATO   = 2'b10,
    RESP   = 2'b11
  } estado_t;

  function automatic logic tam_invalido(
    input logic [1:0] tam,
    input logic [1:0] dir_lo
  );
    logic r;
    r = 1'b0;
    unique case (tam)
      TAM_BYTE:    r = 1'b0;
      TAM_MEDIA:   r = dir_lo[0];
      TAM_PALABRA: r = |dir_lo;
      default:     r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_mem_datos_extrae_carga.sv
// extrae_carga: picks the byte/half lane of a ram word
// and sign- or zero-extends it to 32 bits
module extrae_carga
  import ctrl_mem_datos_pkg::*;
(
  input  logic [31:0] palabra,
  input  logic [1:0]  dir_lo,
  input  logic [1:0]  tam,
  input  logic        sin_signo,
  output logic [31:0] dato
);

  logic [7:0]  byte_sel;
  logic [15:0] media_sel;

  // lane select and extension
  always_comb begin
    byte_sel  = palabra[7:0];
    media_sel = dir_lo[1] ? palabra[31:16] : palabra[15:0];
    unique case (dir_lo)
      2'd0: byte_sel = palabra[7:0];
      2'd1: byte_sel = palabra[15:8];
      2'd2: byte_sel = palabra[23:16];
      2'd3: byte_sel = palabra[31:24];
    endcase
    dato = palabra;
    unique case (tam)
      TAM_BYTE:
        dato = {{24{~sin_signo & byte_sel[7]}}, byte_sel};
      TAM_MEDIA:
        dato = {{16{~sin_signo & media_sel[15]}}, media_sel};
      default:
        dato = palabra;
    endcase
  end

endmodule

// File: rtl/ctrl_mem_datos.sv
// ctrl_mem_datos: byte-addressed load/store front end for a
// word-only ram; sub-word stores are done as read-modify-write
module ctrl_mem_datos
  import ctrl_mem_datos_pkg::*;
#(
  parameter logic [31:0] DIR_BASE  = 32'h0000_0000,
  parameter int          ANCHO_DIR = RAM_ANCHO_DIR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_valido,
  output logic                 cpu_listo,
  input  logic                 cpu_esc,
  input  logic [31:0]          cpu_dir,
  input  logic [1:0]           cpu_tam,
  input  logic                 cpu_sin_signo,
  input  logic [31:0]          cpu_dat_w,
  output logic                 cpu_fin,
  output logic                 cpu_error,
  output logic [31:0]          cpu_dat_r,
  output logic [ANCHO_DIR-1:0] dir_w,
  output logic                 hab_w,
  output logic [31:0]          dat_w,
  output logic [ANCHO_DIR-1:0] dir_r,
  output logic                 hab_r,
  input  logic [31:0]          dat_r
);

  localparam int AD = ANCHO_DIR + 2;
  localparam logic [31:0] MASC_ALTA =
    ~((32'd4 << ANCHO_DIR) - 32'd1);

  estado_t       estado_q, estado_d;
  logic          esc_q, esc_d;
  logic [AD-1:0] dir_q, dir_d;
  logic [1:0]    tam_q, tam_d;
  logic          sgn_q, sgn_d;
  logic [31:0]   dato_q, dato_d;
  logic          error_q, error_d;
  logic [31:0]   dat_r_q, dat_r_d;

  logic          fuera;
  logic          err_pet;
  logic [31:0]   carga;
  logic [31:0]   mezcla;

  extrae_carga u_extrae (
    .palabra   (dat_r),
    .dir_lo    (dir_q[1:0]),
    .tam       (tam_q),
    .sin_signo (sgn_q),
    .dato      (carga)
  );

  assign fuera   = |((cpu_dir ^ DIR_BASE) & MASC_ALTA);
  assign err_pet = fuera | tam_invalido(cpu_tam, cpu_dir[1:0]);

  // merge store data into the word read back from ram
  always_comb begin
    mezcla = dat_r;
    if (tam_q == TAM_BYTE) begin
      unique case (dir_q[1:0])
        2'd0: mezcla[7:0]   = dato_q[7:0];
        2'd1: mezcla[15:8]  = dato_q[7:0];
        2'd2: mezcla[23:16] = dato_q[7:0];
        2'd3: mezcla[31:24] = dato_q[7:0];
      endcase
    end else if (tam_q == TAM_MEDIA) begin
      if (dir_q[1])
        mezcla[31:16] = dato_q[15:0];
      else
        mezcla[15:0] = dato_q[15:0];
    end
  end

  // next state, request latch and ram strobes
  always_comb begin
    estado_d = estado_q;
    esc_d    = esc_q;
    dir_d    = dir_q;
    tam_d    = tam_q;
    sgn_d    = sgn_q;
    dato_d   = dato_q;
    error_d  = error_q;
    dat_r_d  = dat_r_q;
    hab_r    = 1'b0;
    hab_w    = 1'b0;
    unique case (estado_q)
      REPOSO: begin
        if (cpu_valido) begin
          esc_d    = cpu_esc;
          dir_d    = cpu_dir[AD-1:0];
          tam_d    = cpu_tam;
          sgn_d    = cpu_sin_signo;
          dato_d   = cpu_dat_w;
          error_d  = err_pet;
          estado_d = err_pet ? RESP : ACCESO;
        end
      end
      ACCESO: begin
        if (esc_q && tam_q == TAM_PALABRA) begin
          hab_w    = 1'b1;
          estado_d = RESP;
        end else begin
          hab_r    = 1'b1;
          estado_d = DATO;
        end
      end
      DATO: begin
        if (esc_q)
          hab_w = 1'b1;
        else
          dat_r_d = carga;
        estado_d = RESP;
      end
      RESP: estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  // state and latched request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= REPOSO;
      esc_q    <= 1'b0;
      dir_q    <= '0;
      tam_q    <= TAM_BYTE;
      sgn_q    <= 1'b0;
      dato_q   <= '0;
      error_q  <= 1'b0;
      dat_r_q  <= '0;
    end else begin
      estado_q <= estado_d;
      esc_q    <= esc_d;
      dir_q    <= dir_d;
      tam_q    <= tam_d;
      sgn_q    <= sgn_d;
      dato_q   <= dato_d;
      error_q  <= error_d;
      dat_r_q  <= dat_r_d;
    end
  end

  assign cpu_listo = (estado_q == REPOSO);
  assign cpu_fin   = (estado_q == RESP);
  assign cpu_error = (estado_q == RESP) & error_q;
  assign cpu_dat_r = dat_r_q;
  assign dir_r     = dir_q[AD-1:2];
  assign dir_w     = dir_q[AD-1:2];
  assign dat_w     = (estado_q == DATO) ? mezcla : dato_q;

endmodule

// File: tb/tb_ctrl_mem_datos.sv
// tb_ctrl_mem_datos: scoreboard bench for ctrl_mem_datos
// with a behavioural 512x32 ram behind it
module tb_ctrl_mem_datos;

  logic        clk;
  logic        rst_n;
  logic        cpu_valido;
  logic        cpu_listo;
  logic        cpu_esc;
  logic [31:0] cpu_dir;
  logic [1:0]  cpu_tam;
  logic        cpu_sin_signo;
  logic [31:0] cpu_dat_w;
  logic        cpu_fin;
  logic        cpu_error;
  logic [31:0] cpu_dat_r;
  logic [8:0]  dir_w;
  logic        hab_w;
  logic [31:0] dat_w;
  logic [8:0]  dir_r;
  logic        hab_r;
  logic [31:0] dat_r;

  typedef struct {
    logic        esc;
    logic        err;
    logic [8:0]  idx;
    logic [31:0] dat_r_esp;
    logic [31:0] dat_w_esp;
    logic [31:0] viejo;
    int          lat;
    int          n_r;
    int          n_w;
    int          t_acc;
  } esp_t;

  esp_t        cola[$];
  logic [31:0] ram_m   [512];
  logic [31:0] mem_ref [512];
  logic [31:0] ultimo;
  int          ciclo;
  int          cnt_r;
  int          cnt_w;
  int          n_fin;
  int          n_tests;
  int          n_fail;

  ctrl_mem_datos dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_valido    (cpu_valido),
    .cpu_listo     (cpu_listo),
    .cpu_esc       (cpu_esc),
    .cpu_dir       (cpu_dir),
    .cpu_tam       (cpu_tam),
    .cpu_sin_signo (cpu_sin_signo),
    .cpu_dat_w     (cpu_dat_w),
    .cpu_fin       (cpu_fin),
    .cpu_error     (cpu_error),
    .cpu_dat_r     (cpu_dat_r),
    .dir_w         (dir_w),
    .hab_w         (hab_w),
    .dat_w         (dat_w),
    .dir_r         (dir_r),
    .hab_r         (hab_r),
    .dat_r         (dat_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural ram: registered read, synchronous write
  always @(posedge clk) begin
    if (hab_w) ram_m[dir_w] <= dat_w;
    if (hab_r) dat_r <= ram_m[dir_r];
  end

  task automatic chequear(string tag, logic [31:0] obs,
                          logic [31:0] esp);
    n_tests++;
    if (obs !== esp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, esp);
    end
  endtask

  function automatic logic [31:0] carga_ref(
    logic [31:0] w, logic [1:0] lo, logic [1:0] tam, logic sgn);
    logic [31:0] s;
    s = w >> (8 * lo);
    if (tam == 2'b00)
      return sgn ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
    if (tam == 2'b01)
      return sgn ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] mezcla_ref(
    logic [31:0] viejo, logic [31:0] d, logic [1:0] lo,
    logic [1:0] tam);
    logic [31:0] m;
    m = (tam == 2'b00) ? 32'hFF :
        (tam == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    return (viejo & ~(m << (8 * lo))) | ((d & m) << (8 * lo));
  endfunction

  // monitor: ram strobes and completion against the scoreboard
  always @(negedge clk) begin
    ciclo++;
    if (rst_n) begin
      if (hab_r && hab_w) chequear("hab_ambos", 32'd1, 32'd0);
      if (hab_r) begin
        cnt_r++;
        if (cola.size() > 0)
          chequear("dir_r", 32'(dir_r), 32'(cola[0].idx));
      end
      if (hab_w) begin
        cnt_w++;
        if (cola.size() > 0) begin
          chequear("dir_w", 32'(dir_w), 32'(cola[0].idx));
          chequear("dat_w", dat_w, cola[0].dat_w_esp);
        end
      end
      if (cpu_fin) begin
        n_fin++;
        if (cola.size() == 0) begin
          chequear("fin_sin_peticion", 32'd1, 32'd0);
        end else begin
          esp_t e;
          e = cola.pop_front();
          chequear("error", 32'(cpu_error), 32'(e.err));
          chequear("latencia", 32'(ciclo - e.t_acc), 32'(e.lat));
          chequear("n_hab_r", 32'(cnt_r), 32'(e.n_r));
          chequear("n_hab_w", 32'(cnt_w), 32'(e.n_w));
          chequear("listo_en_resp", 32'(cpu_listo), 32'd0);
          if (!e.esc && !e.err) ultimo = e.dat_r_esp;
          chequear("cpu_dat_r", cpu_dat_r, ultimo);
        end
        cnt_r = 0;
        cnt_w = 0;
      end
    end
  end

  task automatic enviar(logic esc, logic [31:0] dir,
                        logic [1:0] tam, logic sgn,
                        logic [31:0] dat, bit mantener);
    esp_t e;
    int   w;
    @(negedge clk); #1;
    cpu_esc       = esc;
    cpu_dir       = dir;
    cpu_tam       = tam;
    cpu_sin_signo = sgn;
    cpu_dat_w     = dat;
    cpu_valido    = 1'b1;
    w = 0;
    while (!cpu_listo && w < 20) begin
      @(negedge clk); #1;
      w++;
    end
    if (!cpu_listo) begin
      chequear("listo_timeout", 32'd0, 32'd1);
      cpu_valido = 1'b0;
      return;
    end
    e.esc = esc;
    e.err = (tam == 2'b11) || (tam == 2'b01 && dir[0]) ||
            (tam == 2'b10 && dir[1:0] != 2'b00) ||
            (dir[31:11] != 21'h0);
    e.idx = dir[10:2];
    e.viejo = mem_ref[e.idx];
    e.dat_r_esp = 32'h0;
    e.dat_w_esp = 32'h0;
    if (e.err) begin
      e.lat = 1; e.n_r = 0; e.n_w = 0;
    end else if (esc) begin
      e.dat_w_esp = mezcla_ref(e.viejo, dat, dir[1:0], tam);
      mem_ref[e.idx] = e.dat_w_esp;
      e.lat = (tam == 2'b10) ? 2 : 3;
      e.n_r = (tam == 2'b10) ? 0 : 1;
      e.n_w = 1;
    end else begin
      e.dat_r_esp = carga_ref(e.viejo, dir[1:0], tam, sgn);
      e.lat = 3; e.n_r = 1; e.n_w = 0;
    end
    e.t_acc = ciclo;
    cola.push_back(e);
    @(posedge clk);
    if (!mantener) begin
      #1;
      cpu_valido = 1'b0;
    end
  endtask

  task automatic esperar_vacia();
    int w;
    w = 0;
    while (cola.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (cola.size() != 0) chequear("fin_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    esp_t d;
    n_tests = 0; n_fail = 0; n_fin = 0;
    ciclo = 0; cnt_r = 0; cnt_w = 0; ultimo = 32'h0;
    dat_r = 32'h0;
    for (int i = 0; i < 512; i++) begin
      ram_m[i]   = 32'h0;
      mem_ref[i] = 32'h0;
    end
    cpu_valido = 1'b0; cpu_esc = 1'b0; cpu_dir = 32'h0;
    cpu_tam = 2'b00; cpu_sin_signo = 1'b0; cpu_dat_w = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chequear("rst_listo", 32'(cpu_listo), 32'd1);
    chequear("rst_fin", 32'(cpu_fin), 32'd0);
    chequear("rst_error", 32'(cpu_error), 32'd0);
    chequear("rst_hab_w", 32'(hab_w), 32'd0);
    chequear("rst_hab_r", 32'(hab_r), 32'd0);
    chequear("rst_dat_r", cpu_dat_r, 32'h0);
    chequear("rst_dat_w", dat_w, 32'h0);
    chequear("rst_dir_w", 32'(dir_w), 32'd0);
    chequear("rst_dir_r", 32'(dir_r), 32'd0);
    #1 rst_n = 1'b1;

    enviar(1'b1, 32'h7FC, 2'b10, 1'b0, 32'hAAAA_AAAA, 1'b0);
    enviar(1'b0, 32'h7FC, 2'b10, 1'b0, 32'h0, 1'b0);
    enviar(1'b1, 32'h010, 2'b10, 1'b0, 32'h8765_43F0, 1'b0);
    enviar(1'b0, 32'h010, 2'b00, 1'b0, 32'h0, 1'b0);
    enviar(1'b0, 32'h010, 2'b00, 1'b1, 32'h0, 1'b0);
    enviar(1'b0, 32'h012, 2'b01, 1'b0, 32'h0, 1'b0);
    enviar(1'b0, 32'h012, 2'b01, 1'b1, 32'h0, 1'b0);
    enviar(1'b1, 32'h011, 2'b00, 1'b0, 32'h0000_00CC, 1'b0);
    enviar(1'b0, 32'h010, 2'b10, 1'b0, 32'h0, 1'b0);
    enviar(1'b0, 32'h011, 2'b01, 1'b0, 32'h0, 1'b0);
    enviar(1'b0, 32'h012, 2'b10, 1'b0, 32'h0, 1'b0);
    enviar(1'b0, 32'h010, 2'b11, 1'b0, 32'h0, 1'b0);
    enviar(1'b0, 32'h800, 2'b10, 1'b0, 32'h0, 1'b0);
    esperar_vacia();
    chequear("ram_0x10_tras_sb", ram_m[4], 32'h8765_CCF0);

    enviar(1'b1, 32'h010, 2'b00, 1'b0, 32'h55, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chequear("rstmid_hab_w", 32'(hab_w), 32'd0);
    chequear("rstmid_hab_r", 32'(hab_r), 32'd0);
    chequear("rstmid_listo", 32'(cpu_listo), 32'd1);
    chequear("rstmid_fin", 32'(cpu_fin), 32'd0);
    chequear("rstmid_error", 32'(cpu_error), 32'd0);
    chequear("rstmid_dat_r", cpu_dat_r, 32'h0);
    chequear("rstmid_dat_w", dat_w, 32'h0);
    chequear("rstmid_dir_w", 32'(dir_w), 32'd0);
    if (cola.size() > 0) begin
      d = cola.pop_back();
      mem_ref[d.idx] = d.viejo;
    end
    ultimo = 32'h0;
    cnt_r = 0;
    cnt_w = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    chequear("ram_sin_escritura", ram_m[4], 32'h8765_CCF0);
    enviar(1'b0, 32'h010, 2'b10, 1'b0, 32'h0, 1'b0);

    enviar(1'b1, 32'h020, 2'b10, 1'b0, 32'h1122_3344, 1'b1);
    enviar(1'b0, 32'h020, 2'b10, 1'b0, 32'h0, 1'b1);
    enviar(1'b0, 32'h023, 2'b00, 1'b1, 32'h0, 1'b0);
    esperar_vacia();
    chequear("n_fin_total", 32'(n_fin), 32'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
